// File: rtl/ss_scan_driver.sv
// Multi-digit seven-segment scan driver: time-multiplexes a packed nibble value onto one
// active-low segment bus, with hex glyphs, leading-zero blanking and frame-synchronised updates.
module ss_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int HEX_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            ss,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] TC       = CW'(SCAN_DIV - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  started;
  logic                  wrap_q;
  logic                  pend;
  logic [4*DIGITS-1:0]   act_val;
  logic [4*DIGITS-1:0]   pend_val;
  logic [DIGITS-1:0]     act_dp;
  logic [DIGITS-1:0]     pend_dp;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            nib;
  logic                  cur_dp;
  logic                  blank;
  logic [DIGITS-1:0]     lz;
  logic                  all_zero;

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    logic [6:0] g;
    g = 7'b1111111;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = (HEX_EN != 0) ? 7'b0001000 : 7'b1111111;
      4'hB: g = (HEX_EN != 0) ? 7'b0000011 : 7'b1111111;
      4'hC: g = (HEX_EN != 0) ? 7'b1000110 : 7'b1111111;
      4'hD: g = (HEX_EN != 0) ? 7'b0100001 : 7'b1111111;
      4'hE: g = (HEX_EN != 0) ? 7'b0000110 : 7'b1111111;
      4'hF: g = (HEX_EN != 0) ? 7'b0001110 : 7'b1111111;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign tick = (cnt == TC);
  assign wrap = tick && (idx == LAST_IDX);

  // lz[i] = digit i and every more-significant digit are zero
  always_comb begin
    lz       = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (act_val[4*i +: 4] == 4'h0);
      lz[i]    = all_zero;
    end
  end

  always_comb begin
    nib    = 4'h0;
    cur_dp = 1'b0;
    blank  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = act_val[4*i +: 4];
        cur_dp = act_dp[i];
        blank  = blank_lz && (i != 0) && lz[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      started    <= 1'b0;
      wrap_q     <= 1'b0;
      pend       <= 1'b0;
      act_val    <= '0;
      pend_val   <= '0;
      act_dp     <= '0;
      pend_dp    <= '0;
      ss         <= 7'b1111111;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      if (tick) begin
        cnt     <= '0;
        idx     <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        started <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      wrap_q     <= wrap;
      frame_done <= wrap_q;

      // A load landing on the wrap tick bypasses the pending stage
      if (wrap && load) begin
        act_val <= value;
        act_dp  <= dp_in;
        pend    <= 1'b0;
      end else begin
        if (wrap && pend) begin
          act_val <= pend_val;
          act_dp  <= pend_dp;
          pend    <= 1'b0;
        end
        if (load) begin
          pend_val <= value;
          pend_dp  <= dp_in;
          pend     <= 1'b1;
        end
      end

      if (started) begin
        ss <= blank ? 7'b1111111 : glyph_of(nib);
        dp <= ~cur_dp;
        an <= ~(DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_ss_scan_driver.sv
// Directed bench for ss_scan_driver (4 digits, 4 clocks per digit), with a HEX_EN=0 twin.
module tb_ss_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0]  ss, ss_n;
  logic        dp, dp_n;
  logic [3:0]  an, an_n;
  logic        frame_done, fd_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ss_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .HEX_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .ss(ss), .dp(dp), .an(an), .frame_done(frame_done)
  );

  ss_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .HEX_EN(0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .ss(ss_n), .dp(dp_n), .an(an_n), .frame_done(fd_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Returns just after the edge where frame_done is high (digit 0 on the outputs)
  task automatic wait_frame();
    int n;
    n = 0;
    step();
    while (frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame frame_done=%b expected 1", frame_done);
    end
  endtask

  task automatic check_frame(input string nm, input logic [3:0][6:0] e_ss,
                             input logic [3:0][6:0] e_nh, input logic [3:0] e_dp);
    logic [3:0] e_an;
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (4) step();
      e_an = ~(4'b0001 << d);
      checks++;
      if (an !== e_an) begin
        errors++;
        $display("FAIL %s an digit%0d got %b expected %b", nm, d, an, e_an);
      end
      checks++;
      if (ss !== e_ss[d]) begin
        errors++;
        $display("FAIL %s ss digit%0d got %b expected %b", nm, d, ss, e_ss[d]);
      end
      checks++;
      if (dp !== e_dp[d]) begin
        errors++;
        $display("FAIL %s dp digit%0d got %b expected %b", nm, d, dp, e_dp[d]);
      end
      checks++;
      if (ss_n !== e_nh[d]) begin
        errors++;
        $display("FAIL %s ss_nohex digit%0d got %b expected %b", nm, d, ss_n, e_nh[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (ss !== 7'b1111111) begin errors++; $display("FAIL reset ss got %b expected 1111111", ss); end
    checks++;
    if (an !== 4'b1111) begin errors++; $display("FAIL reset an got %b expected 1111", an); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL reset dp got %b expected 1", dp); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done got %b expected 0", frame_done); end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] e_an;
    logic [6:0] e_ss;
    logic       e_fd;
    for (int n = 1; n <= 40; n++) begin
      step();
      e_an = (n < 5) ? 4'b1111 : ~(4'b0001 << ((((n - 5) / 4) + 1) % 4));
      e_ss = (n < 5) ? 7'b1111111 : 7'b1000000;
      e_fd = (n >= 17) && (((n - 17) % 16) == 0);
      checks++;
      if (an !== e_an) begin errors++; $display("FAIL scan an cyc%0d got %b expected %b", n, an, e_an); end
      checks++;
      if (ss !== e_ss) begin errors++; $display("FAIL scan ss cyc%0d got %b expected %b", n, ss, e_ss); end
      checks++;
      if (frame_done !== e_fd) begin
        errors++;
        $display("FAIL scan frame_done cyc%0d got %b expected %b", n, frame_done, e_fd);
      end
      checks++;
      if (dp !== 1'b1) begin errors++; $display("FAIL scan dp cyc%0d got %b expected 1", n, dp); end
    end
  endtask

  task automatic test_load();
    wait_frame();
    repeat (9) step();
    pulse_load(16'h1234, 4'b0100);
    checks++;
    if (an !== 4'b1011 || ss !== 7'b1000000) begin
      errors++;
      $display("FAIL load_midframe d2 an=%b ss=%b expected 1011 1000000", an, ss);
    end
    repeat (4) step();
    checks++;
    if (an !== 4'b0111 || ss !== 7'b1000000) begin
      errors++;
      $display("FAIL load_midframe d3 an=%b ss=%b expected 0111 1000000", an, ss);
    end
    wait_frame();
    check_frame("load1234",
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                4'b1011);
  endtask

  task automatic test_blank();
    blank_lz = 1'b1;
    pulse_load(16'h0007, 4'b0000);
    wait_frame();
    check_frame("blank0007",
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000},
                4'b1111);
    pulse_load(16'h0000, 4'b0000);
    wait_frame();
    check_frame("blank0000",
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000},
                4'b1111);
    blank_lz = 1'b0;
  endtask

  task automatic test_hex();
    pulse_load(16'hABCD, 4'b0000);
    wait_frame();
    check_frame("hexABCD",
                {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111},
                4'b1111);
  endtask

  task automatic test_back_to_back();
    wait_frame();
    repeat (2) step();
    pulse_load(16'h1111, 4'b0000);
    repeat (2) step();
    pulse_load(16'h2222, 4'b0000);
    checks++;
    if (an !== 4'b1101 || ss !== 7'b1000110) begin
      errors++;
      $display("FAIL b2b_nomix d1 an=%b ss=%b expected 1101 1000110", an, ss);
    end
    repeat (8) step();
    pulse_load(16'h5678, 4'b0000);
    checks++;
    if (an !== 4'b0111 || ss !== 7'b0001000) begin
      errors++;
      $display("FAIL b2b_nomix d3 an=%b ss=%b expected 0111 0001000", an, ss);
    end
    step();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wrap frame_done got %b expected 1", frame_done);
    end
    check_frame("b2b_wrapload",
                {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000},
                {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000},
                4'b1111);
    wait_frame();
    check_frame("b2b_hold",
                {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000},
                {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000},
                4'b1111);
  endtask

  task automatic test_reset_mid();
    pulse_load(16'h9999, 4'b1111);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (ss !== 7'b1111111) begin errors++; $display("FAIL reset_mid ss got %b expected 1111111", ss); end
    checks++;
    if (an !== 4'b1111) begin errors++; $display("FAIL reset_mid an got %b expected 1111", an); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL reset_mid dp got %b expected 1", dp); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_mid frame_done got %b expected 0", frame_done); end
    #10 rst_n = 1'b1;
    wait_frame();
    check_frame("post_reset",
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                4'b1111);
    wait_frame();
    check_frame("post_reset2",
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                4'b1111);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_blank();
    test_hex();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
